// File: rtl/alarm_clk_pkg.sv
// Shared constants, state encoding and INIT address order for the alarm-clock write side.
package alarm_clk_pkg;

    localparam int unsigned ADDR_CUR_HR  = 0;
    localparam int unsigned ADDR_CUR_MIN = 1;
    localparam int unsigned ADDR_AL_HR   = 2;
    localparam int unsigned ADDR_AL_MIN  = 3;
    localparam int unsigned ADDR_AL_EN   = 5;
    localparam int unsigned ADDR_PARK    = 7;

    localparam int unsigned DEF_HOUR_MAX = 23;
    localparam int unsigned DEF_MIN_MAX  = 59;

    localparam logic [2:0] MODE_IDLE   = 3'd0;
    localparam logic [2:0] MODE_CUR_HR = 3'd1;
    localparam logic [2:0] MODE_CUR_MN = 3'd2;
    localparam logic [2:0] MODE_AL_HR  = 3'd3;
    localparam logic [2:0] MODE_AL_MN  = 3'd4;

    typedef enum logic [3:0] {
        INIT, IDLE, TICK, TOGGLE, SET_CH, SET_CM, SET_AH, SET_AM, COMMIT
    } state_t;

    // Memory locations cleared by the power-on sequence, in write order.
    function automatic int unsigned init_addr(input logic [2:0] step);
        case (step)
            3'd0:    return ADDR_CUR_HR;
            3'd1:    return ADDR_CUR_MIN;
            3'd2:    return ADDR_AL_HR;
            3'd3:    return ADDR_AL_MIN;
            default: return ADDR_AL_EN;
        endcase
    endfunction

endpackage

// File: rtl/wrap_inc.sv
// Increment-with-wrap: returns value+1, or 0 with wrap set once value reaches max_value.
module wrap_inc #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] value,
    input  logic [W-1:0] max_value,
    output logic [W-1:0] next_value,
    output logic         wrap
);

    assign wrap       = (value >= max_value);
    assign next_value = wrap ? '0 : value + W'(1);

endmodule

// File: rtl/alarm_time_writer.sv
// Write-side controller: owns the time/alarm shadows and serialises their updates
// into single-cycle address/data writes, parking on a scratch address otherwise.
module alarm_time_writer
    import alarm_clk_pkg::*;
#(
    parameter int unsigned AW        = 4,
    parameter int unsigned DW        = 8,
    parameter int unsigned HOUR_MAX  = DEF_HOUR_MAX,
    parameter int unsigned MIN_MAX   = DEF_MIN_MAX,
    parameter int unsigned PARK_ADDR = ADDR_PARK
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          btn_mode,
    input  logic          btn_up,
    input  logic          btn_ok,
    input  logic          alarm_toggle,
    input  logic          min_tick,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    output logic          busy,
    output logic [2:0]    mode,
    output logic [DW-1:0] disp_hour,
    output logic [DW-1:0] disp_min
);

    localparam logic [AW-1:0] A_CUR_HR  = AW'(ADDR_CUR_HR);
    localparam logic [AW-1:0] A_CUR_MIN = AW'(ADDR_CUR_MIN);
    localparam logic [AW-1:0] A_AL_HR   = AW'(ADDR_AL_HR);
    localparam logic [AW-1:0] A_AL_MIN  = AW'(ADDR_AL_MIN);
    localparam logic [AW-1:0] A_AL_EN   = AW'(ADDR_AL_EN);
    localparam logic [AW-1:0] A_PARK    = AW'(PARK_ADDR);
    localparam logic [DW-1:0] HR_LIMIT  = DW'(HOUR_MAX);
    localparam logic [DW-1:0] MIN_LIMIT = DW'(MIN_MAX);

    state_t        state;
    logic [2:0]    step;
    logic [1:0]    pend;
    logic [DW-1:0] cur_hr, cur_min, al_hr, al_min;
    logic          al_en;
    logic [DW-1:0] edit_ch, edit_cm, edit_ah, edit_am;
    logic          commit_alarm;

    logic [DW-1:0] tick_min_next, tick_hr_next, edit_val, edit_max, edit_next;
    logic          tick_min_wrap, tick_hr_wrap, edit_wrap;
    logic          unused_wrap;

    wrap_inc #(.W(DW)) u_tick_min (
        .value(cur_min), .max_value(MIN_LIMIT), .next_value(tick_min_next), .wrap(tick_min_wrap)
    );
    wrap_inc #(.W(DW)) u_tick_hr (
        .value(cur_hr), .max_value(HR_LIMIT), .next_value(tick_hr_next), .wrap(tick_hr_wrap)
    );
    wrap_inc #(.W(DW)) u_edit (
        .value(edit_val), .max_value(edit_max), .next_value(edit_next), .wrap(edit_wrap)
    );

    assign unused_wrap = tick_hr_wrap ^ edit_wrap;

    always_comb begin
        edit_val = edit_ch;
        edit_max = HR_LIMIT;
        case (state)
            SET_CM:  begin edit_val = edit_cm; edit_max = MIN_LIMIT; end
            SET_AH:  begin edit_val = edit_ah; edit_max = HR_LIMIT;  end
            SET_AM:  begin edit_val = edit_am; edit_max = MIN_LIMIT; end
            default: ;
        endcase
    end

    // Each accepting edge drives the first write; sequence states drive the rest, then park.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= INIT;
            step         <= '0;
            pend         <= '0;
            cur_hr       <= '0;
            cur_min      <= '0;
            al_hr        <= '0;
            al_min       <= '0;
            al_en        <= 1'b0;
            edit_ch      <= '0;
            edit_cm      <= '0;
            edit_ah      <= '0;
            edit_am      <= '0;
            commit_alarm <= 1'b0;
            mem_addr     <= A_PARK;
            mem_data     <= '0;
            busy         <= 1'b1;
            mode         <= MODE_IDLE;
            disp_hour    <= '0;
            disp_min     <= '0;
        end else begin
            mem_addr <= A_PARK;
            mem_data <= '0;
            busy     <= 1'b0;
            if (state != IDLE && min_tick && pend != 2'd3)
                pend <= pend + 2'd1;

            case (state)
                INIT: begin
                    if (step == 3'd5) begin
                        state <= IDLE;
                        step  <= '0;
                    end else begin
                        mem_addr <= AW'(init_addr(step));
                        busy     <= 1'b1;
                        step     <= step + 3'd1;
                    end
                end
                IDLE: begin
                    if (min_tick || pend != 2'd0) begin
                        cur_min <= tick_min_next;
                        if (tick_min_wrap)
                            cur_hr <= tick_hr_next;
                        if (pend != 2'd0)
                            pend <= pend - 2'd1;
                        mem_addr  <= A_CUR_MIN;
                        mem_data  <= tick_min_next;
                        busy      <= 1'b1;
                        disp_min  <= tick_min_next;
                        disp_hour <= tick_min_wrap ? tick_hr_next : cur_hr;
                        step      <= '0;
                        state     <= TICK;
                    end else if (alarm_toggle) begin
                        al_en    <= ~al_en;
                        mem_addr <= A_AL_EN;
                        mem_data <= {{(DW-1){1'b0}}, ~al_en};
                        busy     <= 1'b1;
                        state    <= TOGGLE;
                    end else if (btn_mode) begin
                        edit_ch <= cur_hr;
                        edit_cm <= cur_min;
                        edit_ah <= al_hr;
                        edit_am <= al_min;
                        mode    <= MODE_CUR_HR;
                        state   <= SET_CH;
                    end
                end
                TICK: begin
                    if (step == 3'd0) begin
                        mem_addr <= A_CUR_HR;
                        mem_data <= cur_hr;
                        busy     <= 1'b1;
                        step     <= 3'd1;
                    end else begin
                        step  <= '0;
                        state <= IDLE;
                    end
                end
                TOGGLE: state <= IDLE;
                SET_CH, SET_CM, SET_AH, SET_AM: begin
                    if (btn_ok) begin
                        if (state == SET_CH || state == SET_CM) begin
                            cur_hr       <= edit_ch;
                            cur_min      <= edit_cm;
                            pend         <= '0;
                            mem_addr     <= A_CUR_HR;
                            mem_data     <= edit_ch;
                            disp_hour    <= edit_ch;
                            disp_min     <= edit_cm;
                            commit_alarm <= 1'b0;
                        end else begin
                            al_hr        <= edit_ah;
                            al_min       <= edit_am;
                            mem_addr     <= A_AL_HR;
                            mem_data     <= edit_ah;
                            disp_hour    <= cur_hr;
                            disp_min     <= cur_min;
                            commit_alarm <= 1'b1;
                        end
                        busy  <= 1'b1;
                        mode  <= MODE_IDLE;
                        step  <= '0;
                        state <= COMMIT;
                    end else if (btn_mode) begin
                        case (state)
                            SET_CH: begin
                                state <= SET_CM;
                                mode  <= MODE_CUR_MN;
                            end
                            SET_CM: begin
                                state     <= SET_AH;
                                mode      <= MODE_AL_HR;
                                disp_hour <= edit_ah;
                                disp_min  <= edit_am;
                            end
                            SET_AH: begin
                                state <= SET_AM;
                                mode  <= MODE_AL_MN;
                            end
                            default: begin
                                state     <= IDLE;
                                mode      <= MODE_IDLE;
                                disp_hour <= cur_hr;
                                disp_min  <= cur_min;
                            end
                        endcase
                    end else if (btn_up) begin
                        case (state)
                            SET_CH:  begin edit_ch <= edit_next; disp_hour <= edit_next; end
                            SET_CM:  begin edit_cm <= edit_next; disp_min  <= edit_next; end
                            SET_AH:  begin edit_ah <= edit_next; disp_hour <= edit_next; end
                            default: begin edit_am <= edit_next; disp_min  <= edit_next; end
                        endcase
                    end
                end
                COMMIT: begin
                    if (step == 3'd0) begin
                        mem_addr <= commit_alarm ? A_AL_MIN : A_CUR_MIN;
                        mem_data <= commit_alarm ? al_min : cur_min;
                        busy     <= 1'b1;
                        step     <= 3'd1;
                    end else begin
                        step  <= '0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= INIT;
                    step  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_time_writer.sv
// Directed scenarios plus random pulses, every cycle compared against a minute-count/write-queue model.
module tb_alarm_time_writer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_mode = 1'b0, btn_up = 1'b0, btn_ok = 1'b0, alarm_toggle = 1'b0, min_tick = 1'b0;
    logic [3:0] mem_addr;
    logic [7:0] mem_data;
    logic       busy;
    logic [2:0] mode;
    logic [7:0] disp_hour, disp_min;

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;

    typedef struct {
        int addr;
        int data;
    } wr_t;
    wr_t wq[$];

    // Model: phase 0 idle, 1..4 edit field, 5 busy draining the write queue.
    int m_phase = 0, m_total = 0, m_al_hr = 0, m_al_min = 0, m_pend = 0;
    bit m_en = 1'b0;
    int e_hr[2], e_min[2];
    int x_addr = 7, x_data = 0, x_busy = 1, x_mode = 0, x_dh = 0, x_dm = 0;

    alarm_time_writer dut (
        .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_up(btn_up), .btn_ok(btn_ok),
        .alarm_toggle(alarm_toggle), .min_tick(min_tick), .mem_addr(mem_addr), .mem_data(mem_data),
        .busy(busy), .mode(mode), .disp_hour(disp_hour), .disp_min(disp_min)
    );

    always #5 clk = ~clk;

    function automatic void push(input int a, input int d);
        wr_t w;
        w.addr = a;
        w.data = d;
        wq.push_back(w);
    endfunction

    function automatic void start_seq();
        wr_t w;
        w = wq.pop_front();
        x_addr  = w.addr;
        x_data  = w.data;
        x_busy  = 1;
        m_phase = 5;
    endfunction

    function automatic void model_step(input bit r, m, u, o, t, k);
        wr_t w;
        int  p;
        if (r) begin
            m_total = 0; m_al_hr = 0; m_al_min = 0; m_en = 1'b0; m_pend = 0;
            wq.delete();
            push(0, 0); push(1, 0); push(2, 0); push(3, 0); push(5, 0);
            m_phase = 5;
            x_addr = 7; x_data = 0; x_busy = 1;
        end else begin
            x_addr = 7; x_data = 0; x_busy = 0;
            if (m_phase != 0 && k && m_pend < 3)
                m_pend++;
            if (m_phase == 5) begin
                if (wq.size() > 0) begin
                    w = wq.pop_front();
                    x_addr = w.addr; x_data = w.data; x_busy = 1;
                end else begin
                    m_phase = 0;
                end
            end else if (m_phase == 0) begin
                if (k || m_pend > 0) begin
                    m_total = (m_total + 1) % 1440;
                    if (m_pend > 0) m_pend--;
                    push(1, m_total % 60);
                    push(0, m_total / 60);
                    start_seq();
                end else if (t) begin
                    m_en = !m_en;
                    push(5, int'(m_en));
                    start_seq();
                end else if (m) begin
                    e_hr[0] = m_total / 60; e_min[0] = m_total % 60;
                    e_hr[1] = m_al_hr;      e_min[1] = m_al_min;
                    m_phase = 1;
                end
            end else begin
                p = (m_phase >= 3) ? 1 : 0;
                if (o) begin
                    if (p == 0) begin
                        m_total = e_hr[0] * 60 + e_min[0];
                        m_pend  = 0;
                        push(0, e_hr[0]); push(1, e_min[0]);
                    end else begin
                        m_al_hr = e_hr[1]; m_al_min = e_min[1];
                        push(2, e_hr[1]); push(3, e_min[1]);
                    end
                    start_seq();
                end else if (m) begin
                    m_phase = (m_phase == 4) ? 0 : m_phase + 1;
                end else if (u) begin
                    if (m_phase == 1 || m_phase == 3)
                        e_hr[p] = (e_hr[p] + 1) % 24;
                    else
                        e_min[p] = (e_min[p] + 1) % 60;
                end
            end
        end
        x_mode = (m_phase >= 1 && m_phase <= 4) ? m_phase : 0;
        if (x_mode != 0) begin
            p = (m_phase >= 3) ? 1 : 0;
            x_dh = e_hr[p]; x_dm = e_min[p];
        end else begin
            x_dh = m_total / 60; x_dm = m_total % 60;
        end
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_miss++;
            $error("[TB] FAIL %s cycle %0d: observed %0d, expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic checkOutput();
        check_val("mem_addr",  {28'b0, mem_addr},  x_addr);
        check_val("mem_data",  {24'b0, mem_data},  x_data);
        check_val("busy",      {31'b0, busy},      x_busy);
        check_val("mode",      {29'b0, mode},      x_mode);
        check_val("disp_hour", {24'b0, disp_hour}, x_dh);
        check_val("disp_min",  {24'b0, disp_min},  x_dm);
    endtask

    task automatic applyStimulus(input bit r, m, u, o, t, k);
        reset = r; btn_mode = m; btn_up = u; btn_ok = o; alarm_toggle = t; min_tick = k;
        @(posedge clk);
        model_step(r, m, u, o, t, k);
        #1;
        cyc++;
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0);
    endtask

    task automatic press_mode(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 1, 0, 0, 0, 0);
    endtask

    task automatic press_up(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 1, 0, 0, 0);
    endtask

    initial begin
        // Power-on clear sequence.
        applyStimulus(1, 0, 0, 0, 0, 0);
        idle(7);
        // Set 23:59 then roll over to 0:00.
        press_mode(1); press_up(23); press_mode(1); press_up(59);
        applyStimulus(0, 0, 0, 1, 0, 0);
        idle(3);
        applyStimulus(0, 0, 0, 0, 0, 1);
        idle(3);
        // Alarm to 07:30.
        press_mode(3); press_up(7); press_mode(1); press_up(30);
        applyStimulus(0, 0, 0, 1, 0, 0);
        idle(3);
        // Current-time commit discards ticks taken during the edit.
        press_mode(1); press_up(10);
        applyStimulus(0, 0, 0, 0, 0, 1);
        press_mode(1); press_up(15);
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 0, 0);
        idle(5);
        // Alarm commit leaves pending ticks to be serviced.
        press_mode(3);
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 0, 0);
        idle(9);
        // Tick wins over toggle in the same cycle.
        applyStimulus(0, 0, 0, 0, 1, 1);
        idle(4);
        applyStimulus(0, 0, 0, 0, 1, 0);
        idle(2);
        // Reset during the second commit write.
        press_mode(1); press_up(3);
        applyStimulus(0, 0, 0, 1, 0, 0);
        idle(1);
        applyStimulus(1, 0, 0, 0, 0, 0);
        idle(7);
        // Random pulse traffic.
        for (int i = 0; i < 1500; i++) begin
            applyStimulus($urandom_range(0, 399) == 0,
                          $urandom_range(0, 99) < 15,
                          $urandom_range(0, 99) < 35,
                          $urandom_range(0, 99) < 8,
                          $urandom_range(0, 99) < 6,
                          $urandom_range(0, 99) < 12);
        end
        idle(4);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
